icache: RTL
===========

Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's instruction port.
- Serves fetch hits with one-cycle registered latency.
- On a miss, requests the word from the memory controller, then fills the line and returns the instruction.
- One outstanding miss at a time; the controller port is strictly request/hold/valid-pulse.

Parameters:
INDEX_BITS, 6, number of index bits; cache holds 2^INDEX_BITS lines of 32 bits (default 64 lines = 256 bytes)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global enable; when low, all state and outputs hold
if_req  input  1  fetch request, sampled only in IDLE
if_addr  input  32  fetch byte address; bits [1:0] ignored
clear  input  1  pipeline flush; cancels any pending/returning response
if_valid  output  1  one-cycle pulse: if_instr valid for the accepted request
if_instr  output  32  fetched instruction
mem_en  output  1  instruction read request to memory controller (instr_out_enable)
mem_addr  output  32  word-aligned read address (instr_out_addr)
mem_valid  input  1  controller completion pulse (instr_out_valid)
mem_instr  input  32  controller read data (instr_out)

Behaviour:
- Address split:
  - index = if_addr[INDEX_BITS+1:2]
  - tag = if_addr[31:INDEX_BITS+2]
- Storage per line: valid bit, tag, 32-bit data.
- Reset (async, rst=1):
  - All valid bits cleared; state IDLE; cancel flag cleared.
  - if_valid=0, if_instr=0, mem_en=0, mem_addr=0.
  - Data/tag arrays need no reset.
- rdy=0: nothing changes, including sampling of mem_valid and if_req.
- State IDLE, each cycle with rdy=1:
  - if_valid<=0 by default.
  - clear=1: no lookup; request dropped; stay IDLE. clear wins over a simultaneous if_req.
  - if_req=1, line valid and tag match (hit): next cycle if_valid=1 and if_instr=line data; stay IDLE. Back-to-back hits give one response per cycle.
  - if_req=1, miss: next cycle mem_en=1 and mem_addr={if_addr[31:2],2'b00}. Latch index/tag; cancel<=0; go MISS.
- State MISS:
  - mem_en and mem_addr hold stable until mem_valid.
  - if_req is ignored; the fetch stage must hold off until if_valid.
  - clear=1 in any MISS cycle sets cancel<=1. The memory read is not aborted, because the controller cannot abandon a transfer.
  - On mem_valid=1:
    - Write line (valid=1, latched tag, mem_instr).
    - mem_en<=0, mem_addr<=0.
    - If cancel=0 and clear=0 that cycle: if_valid<=1, if_instr<=mem_instr. Otherwise if_valid stays 0.
    - Go IDLE.
  - mem_en drops the cycle after mem_valid. This lands in the controller's post-transfer idle cycle, so no duplicate read is issued.
  - A new request may be accepted in the first IDLE cycle.
- Miss latency: request cycle + 1 cycle to raise mem_en + controller transfer time, with if_valid registered on the mem_valid edge.
- Conflict: a fill overwrites any prior line at that index unconditionally.
- No write path; self-modifying code is not supported. Only reset invalidates lines.
- if_instr holds its last value when if_valid=0.

Test Plan:
- Cold miss: reset, if_req with if_addr=0x0000_0100, mem model returns 0x0050_0093 after 5 cycles → mem_en=1 with mem_addr=0x100 the next cycle, held until mem_valid; then one if_valid pulse with if_instr=0x0050_0093; mem_en low one cycle after mem_valid.
- Hit: repeat 0x102 after the fill → if_valid=1, if_instr=0x0050_0093 one cycle later; mem_en never asserts. Four consecutive hits give four consecutive if_valid cycles.
- Conflict: fill 0x100 (data A), then fetch 0x200 (same index 0, data B) → miss, mem_addr=0x200. A refetch of 0x100 then misses again and returns A.
- Flush during miss: miss on 0x40, assert clear for 1 cycle mid-transfer → no if_valid pulse. A later fetch of 0x40 hits with the filled data.
- Clear with hit request in the same cycle → no if_valid next cycle.
- rdy/reset: drop rdy for 3 cycles mid-miss → mem_en/mem_addr held, no state advance. Assert rst mid-miss → mem_en=0 and if_valid=0 immediately (async); the prior hit line is now a miss.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller's instruction port; one outstanding miss at a time.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        clear,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_instr
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  // Even parity over a stored line; a corrupted line reads as a miss and is refetched.
  function automatic logic line_parity(input logic [TAG_BITS-1:0] tag,
                                       input logic [31:0]         data);
    return ^{tag, data};
  endfunction

  // Line storage
  logic [LINES-1:0]    valid_r;
  logic [LINES-1:0]    par_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [31:0]         data_r [LINES];

  // Control and registered outputs
  state_t                state_r, state_s;
  logic                  if_valid_r, if_valid_s;
  logic [31:0]           if_instr_r, if_instr_s;
  logic                  mem_en_r, mem_en_s;
  logic [31:0]           mem_addr_r, mem_addr_s;
  logic                  cancel_r, cancel_s;
  logic [INDEX_BITS-1:0] miss_idx_r, miss_idx_s;
  logic [TAG_BITS-1:0]   miss_tag_r, miss_tag_s;
  logic                  fill_s;

  // Lookup
  logic [INDEX_BITS-1:0] lkp_idx_s;
  logic [TAG_BITS-1:0]   lkp_tag_s;
  logic                  hit_s;
  logic [1:0]            unused_addr_s;

  assign lkp_idx_s     = if_addr[INDEX_BITS+1:2];
  assign lkp_tag_s     = if_addr[31:INDEX_BITS+2];
  assign unused_addr_s = if_addr[1:0];

  assign if_valid = if_valid_r;
  assign if_instr = if_instr_r;
  assign mem_en   = mem_en_r;
  assign mem_addr = mem_addr_r;

  // Hit detection: valid, tag match and intact parity
  always_comb begin
    hit_s = 1'b0;
    if (valid_r[lkp_idx_s] &&
        (tag_r[lkp_idx_s] == lkp_tag_s) &&
        (par_r[lkp_idx_s] == line_parity(tag_r[lkp_idx_s], data_r[lkp_idx_s]))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    if_valid_s = 1'b0;
    if_instr_s = if_instr_r;
    mem_en_s   = mem_en_r;
    mem_addr_s = mem_addr_r;
    cancel_s   = cancel_r;
    miss_idx_s = miss_idx_r;
    miss_tag_s = miss_tag_r;
    fill_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_s = ST_IDLE;
        end else if (if_req) begin
          if (hit_s) begin
            if_valid_s = 1'b1;
            if_instr_s = data_r[lkp_idx_s];
          end else begin
            mem_en_s   = 1'b1;
            mem_addr_s = {if_addr[31:2], 2'b00};
            miss_idx_s = lkp_idx_s;
            miss_tag_s = lkp_tag_s;
            cancel_s   = 1'b0;
            state_s    = ST_MISS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MISS: begin
        // The transfer itself cannot be aborted, only its response suppressed
        if (mem_valid) begin
          fill_s     = 1'b1;
          mem_en_s   = 1'b0;
          mem_addr_s = 32'h0000_0000;
          state_s    = ST_IDLE;
          if (!cancel_r && !clear) begin
            if_valid_s = 1'b1;
            if_instr_s = mem_instr;
          end else begin
            if_valid_s = 1'b0;
          end
        end else if (clear) begin
          cancel_s = 1'b1;
        end else begin
          state_s = ST_MISS;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        mem_en_s   = 1'b0;
        mem_addr_s = 32'h0000_0000;
      end
    endcase
  end

  // Control and output registers; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      if_valid_r <= 1'b0;
      if_instr_r <= 32'h0000_0000;
      mem_en_r   <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      cancel_r   <= 1'b0;
      miss_idx_r <= {INDEX_BITS{1'b0}};
      miss_tag_r <= {TAG_BITS{1'b0}};
    end else if (rdy) begin
      state_r    <= state_s;
      if_valid_r <= if_valid_s;
      if_instr_r <= if_instr_s;
      mem_en_r   <= mem_en_s;
      mem_addr_r <= mem_addr_s;
      cancel_r   <= cancel_s;
      miss_idx_r <= miss_idx_s;
      miss_tag_r <= miss_tag_s;
    end
  end

  // Valid bits: only reset invalidates, fills always set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (rdy && fill_s) begin
      valid_r[miss_idx_r] <= 1'b1;
    end
  end

  // Tag, data and parity arrays, written on fill without reset
  always_ff @(posedge clk) begin
    if (rdy && fill_s) begin
      tag_r[miss_idx_r]  <= miss_tag_r;
      data_r[miss_idx_r] <= mem_instr;
      par_r[miss_idx_r]  <= line_parity(miss_tag_r, mem_instr);
    end
  end

endmodule
